// File: rtl/instr_decode_ctrl_if.sv
// instr_decode_ctrl_if -- fetch <-> decode/control handshake.
//   instr_in/instr_valid : fetched word and its qualifier (fetch -> decode)
//   pc_update            : one-cycle PC advance strobe (decode -> fetch)
//   jump/jump_reg/branch/inv_zero : PC steering, meaningful with pc_update
//   target/imm16         : IR fields the fetch unit uses to build the next PC
// master = fetch unit, slave = decode/control unit.
interface instr_decode_ctrl_if;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        pc_update;
  logic        jump;
  logic        jump_reg;
  logic        branch;
  logic        inv_zero;
  logic [25:0] target;
  logic [15:0] imm16;

  modport master (
    output instr_in, instr_valid,
    input  pc_update, jump, jump_reg, branch, inv_zero, target, imm16
  );

  modport slave (
    input  instr_in, instr_valid,
    output pc_update, jump, jump_reg, branch, inv_zero, target, imm16
  );
endinterface

// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl -- multi-cycle MIPS-subset decode and control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB, one pc_update pulse per instruction.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   fetch (slave)   : instruction handshake and PC-steering flags
//   rs_addr/rt_addr : register read addresses (IR fields)
//   wb_addr         : write-back register number
//   alu_ctrl        : 000 ADD, 001 SUB, 010 XOR, 011 SLT
//   alu_src_imm, zero_ext, mem_we, mem_re, mem_to_reg, reg_we, link
//   illegal         : one-cycle pulse in EXEC on undefined opcode/funct
//   retired_cnt     : retired-instruction count
// Parameters: MEM_LAT (1..15) cycles in MEM, LINK_REG register written by JAL.
// Macro RETIRE_CNT_EN: build the retired-instruction counter; otherwise
// retired_cnt is tied to 0.
// All outputs are registered copies of a decode of the next state, so they
// behave as Moore outputs of the registered state/IR and are 0 after reset.
module instr_decode_ctrl #(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                clk,
  input  logic                reset,
  instr_decode_ctrl_if.slave  fetch,
  output logic [4:0]          rs_addr,
  output logic [4:0]          rt_addr,
  output logic [4:0]          wb_addr,
  output logic [2:0]          alu_ctrl,
  output logic                alu_src_imm,
  output logic                zero_ext,
  output logic                mem_we,
  output logic                mem_re,
  output logic                mem_to_reg,
  output logic                reg_we,
  output logic                link,
  output logic                illegal,
  output logic [31:0]         retired_cnt
);

  localparam logic [3:0] MEM_LAST  = 4'(MEM_LAT - 1);
  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [3:0] {
    C_ILL, C_ADD, C_SUB, C_SLT, C_JR, C_LW, C_SW, C_XORI, C_BEQ, C_BNE, C_J, C_JAL
  } cls_t;

  function automatic cls_t classify(input logic [31:0] ir);
    cls_t c;
    c = C_ILL;
    case (ir[31:26])
      6'h00: case (ir[5:0])
        6'h20:   c = C_ADD;
        6'h22:   c = C_SUB;
        6'h2A:   c = C_SLT;
        6'h08:   c = C_JR;
        default: c = C_ILL;
      endcase
      6'h23:   c = C_LW;
      6'h2B:   c = C_SW;
      6'h0E:   c = C_XORI;
      6'h04:   c = C_BEQ;
      6'h05:   c = C_BNE;
      6'h02:   c = C_J;
      6'h03:   c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  cnt_q, cnt_d;
  cls_t        cls_cur, cls_nxt;

  // next-state outputs
  logic        pc_update_d, jump_d, jump_reg_d, branch_d, inv_zero_d;
  logic [4:0]  wb_addr_d;
  logic [2:0]  alu_ctrl_d;
  logic        alu_src_imm_d, zero_ext_d, mem_we_d, mem_re_d;
  logic        mem_to_reg_d, reg_we_d, link_d, illegal_d;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    cls_cur = classify(ir_q);
    case (state_q)
      S_FETCH: if (fetch.instr_valid) begin
        ir_d    = fetch.instr_in;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        cnt_d = '0;
        case (cls_cur)
          C_LW, C_SW:                        state_d = S_MEM;
          C_ADD, C_SUB, C_SLT, C_XORI, C_JAL: state_d = S_WB;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (cnt_q == MEM_LAST) state_d = (cls_cur == C_LW) ? S_WB : S_FETCH;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode of the state being entered; registered below.
  always_comb begin
    cls_nxt       = classify(ir_d);
    pc_update_d   = 1'b0;
    jump_d        = 1'b0;
    jump_reg_d    = 1'b0;
    branch_d      = 1'b0;
    inv_zero_d    = 1'b0;
    wb_addr_d     = '0;
    alu_ctrl_d    = 3'b000;
    alu_src_imm_d = 1'b0;
    zero_ext_d    = 1'b0;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    mem_to_reg_d  = 1'b0;
    reg_we_d      = 1'b0;
    link_d        = 1'b0;
    illegal_d     = 1'b0;

    if (state_d == S_EXEC) begin
      pc_update_d = 1'b1;
      jump_d      = (cls_nxt == C_J) || (cls_nxt == C_JAL);
      jump_reg_d  = (cls_nxt == C_JR);
      branch_d    = (cls_nxt == C_BEQ) || (cls_nxt == C_BNE);
      inv_zero_d  = (cls_nxt == C_BNE);
      illegal_d   = (cls_nxt == C_ILL);
    end

    if (state_d == S_EXEC || state_d == S_MEM || state_d == S_WB) begin
      case (cls_nxt)
        C_SUB, C_BEQ, C_BNE: alu_ctrl_d = 3'b001;
        C_XORI:              alu_ctrl_d = 3'b010;
        C_SLT:               alu_ctrl_d = 3'b011;
        default:             alu_ctrl_d = 3'b000;
      endcase
      alu_src_imm_d = (cls_nxt == C_LW) || (cls_nxt == C_SW) || (cls_nxt == C_XORI);
      zero_ext_d    = (cls_nxt == C_XORI);
      case (cls_nxt)
        C_ADD, C_SUB, C_SLT: wb_addr_d = ir_d[15:11];
        C_LW, C_XORI:        wb_addr_d = ir_d[20:16];
        C_JAL:               wb_addr_d = LINK_ADDR;
        default:             wb_addr_d = '0;
      endcase
    end

    if (state_d == S_MEM) begin
      mem_we_d = (cls_nxt == C_SW) && (cnt_d == 4'd0);
      mem_re_d = (cls_nxt == C_LW);
    end

    if (state_d == S_WB) begin
      reg_we_d     = (wb_addr_d != 5'd0);  // $0 writes are dropped
      mem_to_reg_d = (cls_nxt == C_LW);
      link_d       = (cls_nxt == C_JAL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_FETCH;
      ir_q              <= '0;
      cnt_q             <= '0;
      fetch.pc_update   <= 1'b0;
      fetch.jump        <= 1'b0;
      fetch.jump_reg    <= 1'b0;
      fetch.branch      <= 1'b0;
      fetch.inv_zero    <= 1'b0;
      fetch.target      <= '0;
      fetch.imm16       <= '0;
      rs_addr           <= '0;
      rt_addr           <= '0;
      wb_addr           <= '0;
      alu_ctrl          <= '0;
      alu_src_imm       <= 1'b0;
      zero_ext          <= 1'b0;
      mem_we            <= 1'b0;
      mem_re            <= 1'b0;
      mem_to_reg        <= 1'b0;
      reg_we            <= 1'b0;
      link              <= 1'b0;
      illegal           <= 1'b0;
    end else begin
      state_q           <= state_d;
      ir_q              <= ir_d;
      cnt_q             <= cnt_d;
      fetch.pc_update   <= pc_update_d;
      fetch.jump        <= jump_d;
      fetch.jump_reg    <= jump_reg_d;
      fetch.branch      <= branch_d;
      fetch.inv_zero    <= inv_zero_d;
      fetch.target      <= ir_d[25:0];
      fetch.imm16       <= ir_d[15:0];
      rs_addr           <= ir_d[25:21];
      rt_addr           <= ir_d[20:16];
      wb_addr           <= wb_addr_d;
      alu_ctrl          <= alu_ctrl_d;
      alu_src_imm       <= alu_src_imm_d;
      zero_ext          <= zero_ext_d;
      mem_we            <= mem_we_d;
      mem_re            <= mem_re_d;
      mem_to_reg        <= mem_to_reg_d;
      reg_we            <= reg_we_d;
      link              <= link_d;
      illegal           <= illegal_d;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [31:0] ret_cnt_q;
  logic        retire;

  // Final cycle of a legal instruction: EXEC for control transfers, last MEM
  // cycle for SW, WB for everything that writes back (even to $0).
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_EXEC:  retire = (cls_cur == C_J) || (cls_cur == C_JR) ||
                        (cls_cur == C_BEQ) || (cls_cur == C_BNE);
      S_MEM:   retire = (cls_cur == C_SW) && (cnt_q == MEM_LAST);
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       ret_cnt_q <= '0;
    else if (retire) ret_cnt_q <= ret_cnt_q + 32'd1;
  end

  assign retired_cnt = ret_cnt_q;
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl (MEM_LAT=3). Inputs change and outputs
// are sampled on the falling edge; expected values are hand-derived.
module tb_instr_decode_ctrl;
  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_decode_ctrl_if fif();

  logic [4:0]  rs_addr, rt_addr, wb_addr;
  logic [2:0]  alu_ctrl;
  logic        alu_src_imm, zero_ext, mem_we, mem_re, mem_to_reg, reg_we, link, illegal;
  logic [31:0] retired_cnt;

  instr_decode_ctrl #(.MEM_LAT(MEM_LAT), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .fetch(fif.slave),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .wb_addr(wb_addr),
    .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .zero_ext(zero_ext),
    .mem_we(mem_we), .mem_re(mem_re), .mem_to_reg(mem_to_reg),
    .reg_we(reg_we), .link(link), .illegal(illegal), .retired_cnt(retired_cnt)
  );

  logic [3:0] flags;  // {jump, jump_reg, branch, inv_zero}
  logic       any_o;
  assign flags = {fif.jump, fif.jump_reg, fif.branch, fif.inv_zero};
  assign any_o = |{fif.pc_update, flags, fif.target, fif.imm16, rs_addr, rt_addr,
                   wb_addr, alu_ctrl, alu_src_imm, zero_ext, mem_we, mem_re,
                   mem_to_reg, reg_we, link, illegal, retired_cnt};

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_ret = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic bump();
`ifdef RETIRE_CNT_EN
    exp_ret = exp_ret + 32'd1;
`endif
  endtask

  // Present a word in FETCH; returns at the DECODE-cycle sample point.
  task automatic issue(input logic [31:0] w);
    fif.instr_valid = 1'b1;
    fif.instr_in    = w;
    cyc();
    fif.instr_valid = 1'b0;
    fif.instr_in    = 32'hDEAD_BEEF;
  endtask

  initial begin
    reset           = 1'b1;
    fif.instr_valid = 1'b0;
    fif.instr_in    = '0;
    cyc(); cyc();
    chk("rst_all0", 32'(any_o), 0);
    reset = 1'b0;
    cyc(); cyc();
    chk("idle_all0", 32'(any_o), 0);

    // ADD $3,$1,$2
    issue(32'h0022_1820);
    chk("add_dec_pc", 32'(fif.pc_update), 0);
    chk("add_rs", 32'(rs_addr), 1);
    chk("add_rt", 32'(rt_addr), 2);
    cyc();
    chk("add_ex_pc", 32'(fif.pc_update), 1);
    chk("add_ex_flg", 32'(flags), 0);
    chk("add_ex_we", 32'(reg_we), 0);
    cyc();
    chk("add_wb_we", 32'(reg_we), 1);
    chk("add_wb_adr", 32'(wb_addr), 3);
    chk("add_wb_alu", 32'(alu_ctrl), 0);
    chk("add_wb_pc", 32'(fif.pc_update), 0);
    chk("add_wb_m2r", 32'(mem_to_reg), 0);
    bump();
    cyc();
    chk("add_fe_we", 32'(reg_we), 0);
    chk("add_ret", retired_cnt, exp_ret);

    // LW $5,4($2)
    issue(32'h8C45_0004);
    cyc();
    chk("lw_ex_pc", 32'(fif.pc_update), 1);
    chk("lw_ex_flg", 32'(flags), 0);
    chk("lw_ex_imm", 32'(alu_src_imm), 1);
    chk("lw_ex_i16", 32'(fif.imm16), 32'h4);
    for (int i = 0; i < MEM_LAT; i++) begin
      cyc();
      chk("lw_mem_re", 32'(mem_re), 1);
      chk("lw_mem_we", 32'(mem_we), 0);
      chk("lw_mem_rwe", 32'(reg_we), 0);
    end
    cyc();
    chk("lw_wb_re", 32'(mem_re), 0);
    chk("lw_wb_we", 32'(reg_we), 1);
    chk("lw_wb_adr", 32'(wb_addr), 5);
    chk("lw_wb_m2r", 32'(mem_to_reg), 1);
    chk("lw_wb_ret", retired_cnt, exp_ret);
    bump();
    cyc();
    chk("lw_fe_we", 32'(reg_we), 0);
    chk("lw_ret", retired_cnt, exp_ret);

    // BNE $1,$2,3
    issue(32'h1422_0003);
    cyc();
    chk("bne_ex_pc", 32'(fif.pc_update), 1);
    chk("bne_ex_flg", 32'(flags), 32'b0011);
    chk("bne_ex_i16", 32'(fif.imm16), 3);
    chk("bne_ex_alu", 32'(alu_ctrl), 1);
    chk("bne_ex_we", 32'(reg_we), 0);
    bump();
    cyc();
    chk("bne_fe_pc", 32'(fif.pc_update), 0);
    chk("bne_fe_flg", 32'(flags), 0);
    chk("bne_fe_we", 32'(reg_we), 0);
    chk("bne_ret", retired_cnt, exp_ret);

    // JAL 9
    issue(32'h0C00_0009);
    cyc();
    chk("jal_ex_pc", 32'(fif.pc_update), 1);
    chk("jal_ex_flg", 32'(flags), 32'b1000);
    chk("jal_ex_tgt", 32'(fif.target), 9);
    cyc();
    chk("jal_wb_we", 32'(reg_we), 1);
    chk("jal_wb_adr", 32'(wb_addr), 31);
    chk("jal_wb_lnk", 32'(link), 1);
    chk("jal_wb_flg", 32'(flags), 0);
    bump();
    cyc();

    // JR $31
    issue(32'h03E0_0008);
    cyc();
    chk("jr_ex_pc", 32'(fif.pc_update), 1);
    chk("jr_ex_flg", 32'(flags), 32'b0100);
    chk("jr_ex_we", 32'(reg_we), 0);
    bump();
    cyc();
    chk("jr_fe_we", 32'(reg_we), 0);
    chk("jr_ret", retired_cnt, exp_ret);

    // undefined opcode
    issue(32'hFC00_0000);
    cyc();
    chk("ill_ex_ill", 32'(illegal), 1);
    chk("ill_ex_pc", 32'(fif.pc_update), 1);
    chk("ill_ex_flg", 32'(flags), 0);
    cyc();
    chk("ill_fe_ill", 32'(illegal), 0);
    chk("ill_fe_we", 32'(reg_we | mem_we), 0);
    chk("ill_ret", retired_cnt, exp_ret);

    // XORI $3,$2,0xFFFF
    issue(32'h3843_FFFF);
    cyc();
    chk("xori_alu", 32'(alu_ctrl), 2);
    chk("xori_zext", 32'(zero_ext), 1);
    chk("xori_imm", 32'(alu_src_imm), 1);
    chk("xori_i16", 32'(fif.imm16), 32'hFFFF);
    cyc();
    chk("xori_wb_we", 32'(reg_we), 1);
    chk("xori_wb_adr", 32'(wb_addr), 3);
    bump();
    cyc();

    // ADD $0,$1,$2 : write suppressed, still retires
    issue(32'h0022_0020);
    cyc(); cyc();
    chk("r0_wb_we", 32'(reg_we), 0);
    bump();
    cyc();
    chk("r0_ret", retired_cnt, exp_ret);

    // SW $5,8($2), full run
    issue(32'hAC45_0008);
    cyc();
    chk("sw_ex_imm", 32'(alu_src_imm), 1);
    chk("sw_ex_mwe", 32'(mem_we), 0);
    cyc();
    chk("sw_m1_we", 32'(mem_we), 1);
    chk("sw_m1_re", 32'(mem_re), 0);
    for (int i = 1; i < MEM_LAT; i++) begin
      cyc();
      chk("sw_mn_we", 32'(mem_we), 0);
    end
    chk("sw_last_ret", retired_cnt, exp_ret);
    bump();
    cyc();
    chk("sw_fe_we", 32'(mem_we | reg_we), 0);
    chk("sw_ret", retired_cnt, exp_ret);

    // SW with reset in its second MEM cycle
    issue(32'hAC45_0008);
    cyc(); cyc();
    chk("swr_m1_we", 32'(mem_we), 1);
    cyc();
    reset = 1'b1;
    cyc();
    exp_ret = '0;
    chk("swr_rst_all0", 32'(any_o), 0);
    cyc();
    chk("swr_hold_all0", 32'(any_o), 0);
    reset = 1'b0;

    // ADD after reset must run the normal 4-cycle sequence
    issue(32'h0022_1820);
    cyc();
    chk("post_ex_pc", 32'(fif.pc_update), 1);
    chk("post_ex_mwe", 32'(mem_we), 0);
    cyc();
    chk("post_wb_we", 32'(reg_we), 1);
    chk("post_wb_adr", 32'(wb_addr), 3);
    bump();
    cyc();
    chk("post_ret", retired_cnt, exp_ret);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
